if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 91 +++++++++
 tb/tb_if_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC select, synchronous IM interface
// and the decode-side instruction slot with hold/replay, flush and fetch counting.
//
// state  | meaning
// BOOT   | first cycle after reset; IM_DO not yet valid, slot forced to NOP
// RUN    | normal fetch; slot driven from IM_DO, replay register or NOP
module if_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic [1:0]  instr_sel,
  input  logic [31:0] target_pc,
  input  logic [31:0] IM_DO,
  output logic [31:0] im_addr,
  output logic        IM_CEB,
  output logic [31:0] pc_ID,
  output logic [31:0] instr_ID,
  output logic        valid_ID,
  output logic [31:0] fetch_cnt
);

  localparam logic [0:0]  S_BOOT = 1'b0;
  localparam logic [0:0]  S_RUN  = 1'b1;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic [0:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_id;
  logic [31:0] r_instr_hold;
  logic        r_valid_hold;
  logic [31:0] r_fetch_cnt;

  logic [31:0] w_pc_next;
  logic [31:0] w_instr;
  logic        w_valid;
  logic        w_fetch_inc;

  // Next PC depends only on pc_sel/target_pc, never on IM_DO.
  always_comb begin
    case (pc_sel)
      2'b01:   w_pc_next = target_pc & 32'hFFFF_FFFC;
      2'b10:   w_pc_next = r_pc;
      default: w_pc_next = r_pc + 32'd4;
    endcase
  end

  always_comb begin
    w_instr = NOP;
    w_valid = 1'b0;
    if (r_state == S_RUN) begin
      if (instr_sel[1]) begin
        w_instr = NOP;
        w_valid = 1'b0;
      end else if (instr_sel[0]) begin
        w_instr = r_instr_hold;
        w_valid = r_valid_hold;
      end else begin
        w_instr = IM_DO;
        w_valid = 1'b1;
      end
    end
  end

  assign w_fetch_inc = w_valid && (instr_sel == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_pc         <= 32'd0;
      r_pc_id      <= 32'd0;
      r_instr_hold <= NOP;
      r_valid_hold <= 1'b0;
      r_fetch_cnt  <= 32'd0;
    end else begin
      r_state      <= S_RUN;
      r_pc         <= w_pc_next;
      r_instr_hold <= w_instr;
      r_valid_hold <= w_valid;
      if (pc_sel != 2'b10) r_pc_id <= r_pc;
      if (w_fetch_inc) r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign im_addr   = r_pc;
  assign IM_CEB    = rst;
  assign pc_ID     = r_pc_id;
  assign instr_ID  = w_instr;
  assign valid_ID  = w_valid;
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random traffic against a
// cycle-level model of the fetch rules, with a synchronous IM behind im_addr.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pc_sel = 2'b00;
  logic [1:0]  instr_sel = 2'b00;
  logic [31:0] target_pc = 32'd0;
  logic [31:0] IM_DO = 32'd0;
  logic [31:0] im_addr;
  logic        IM_CEB;
  logic [31:0] pc_ID;
  logic [31:0] instr_ID;
  logic        valid_ID;
  logic [31:0] fetch_cnt;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_stage dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .instr_sel(instr_sel),
    .target_pc(target_pc), .IM_DO(IM_DO), .im_addr(im_addr), .IM_CEB(IM_CEB),
    .pc_ID(pc_ID), .instr_ID(instr_ID), .valid_ID(valid_ID), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] im_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  // Synchronous instruction memory: data for an address appears one edge later.
  always @(posedge clk) IM_DO <= im_word(im_addr);

  // Reference model state
  bit          m_run;
  logic [31:0] m_pc, m_pcid, m_hold_i, m_cnt, m_im;
  logic        m_hold_v;

  function automatic logic [31:0] exp_instr();
    if (!m_run || instr_sel[1]) return NOP;
    if (instr_sel[0]) return m_hold_i;
    return m_im;
  endfunction

  function automatic logic exp_valid();
    if (!m_run || instr_sel[1]) return 1'b0;
    if (instr_sel[0]) return m_hold_v;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pc = 0; m_pcid = 0; m_hold_i = NOP; m_hold_v = 0; m_cnt = 0; m_im = 0;
  endtask

  // Called just after a falling edge: drive the cycle's inputs and let comb settle.
  task automatic set_in(input logic [1:0] ps, input logic [1:0] is, input logic [31:0] tg);
    pc_sel = ps; instr_sel = is; target_pc = tg;
    #1;
  endtask

  // Advance one clock and apply the fetch rules to the model.
  task automatic tick();
    logic [31:0] ei;
    logic        ev;
    ei = exp_instr();
    ev = exp_valid();
    @(posedge clk);
    if (ev && instr_sel == 2'b00) m_cnt = m_cnt + 1;
    m_hold_i = ei;
    m_hold_v = ev;
    m_im = im_word(m_pc);
    if (pc_sel != 2'b10) m_pcid = m_pc;
    if (pc_sel == 2'b01)      m_pc = {target_pc[31:2], 2'b00};
    else if (pc_sel != 2'b10) m_pc = m_pc + 4;
    m_run = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    set_in(2'b00, 2'b00, 32'd0);
    n_total++; if (im_addr !== 32'd0) $display("FAIL rst_pc got %h exp %h", im_addr, 32'd0); else n_pass++;
    n_total++; if (pc_ID !== 32'd0) $display("FAIL rst_pcid got %h exp %h", pc_ID, 32'd0); else n_pass++;
    n_total++; if (instr_ID !== NOP) $display("FAIL rst_instr got %h exp %h", instr_ID, NOP); else n_pass++;
    n_total++; if (valid_ID !== 1'b0) $display("FAIL rst_valid got %b exp 0", valid_ID); else n_pass++;
    n_total++; if (fetch_cnt !== 32'd0) $display("FAIL rst_cnt got %h exp 0", fetch_cnt); else n_pass++;
    n_total++; if (IM_CEB !== 1'b1) $display("FAIL rst_ceb got %b exp 1", IM_CEB); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_fetch();
    set_in(2'b00, 2'b00, 32'd0);
    n_total++; if (instr_ID !== NOP) $display("FAIL boot_instr got %h exp %h", instr_ID, NOP); else n_pass++;
    n_total++; if (valid_ID !== 1'b0) $display("FAIL boot_valid got %b exp 0", valid_ID); else n_pass++;
    n_total++; if (IM_CEB !== 1'b0) $display("FAIL run_ceb got %b exp 0", IM_CEB); else n_pass++;
    tick();
    set_in(2'b00, 2'b00, 32'd0);
    n_total++; if (pc_ID !== 32'd0) $display("FAIL c1_pcid got %h exp 0", pc_ID); else n_pass++;
    n_total++; if (instr_ID !== im_word(32'd0)) $display("FAIL c1_instr got %h exp %h", instr_ID, im_word(32'd0)); else n_pass++;
    n_total++; if (valid_ID !== 1'b1) $display("FAIL c1_valid got %b exp 1", valid_ID); else n_pass++;
    tick();
    set_in(2'b00, 2'b00, 32'd0);
    n_total++; if (pc_ID !== 32'd4) $display("FAIL c2_pcid got %h exp 4", pc_ID); else n_pass++;
    n_total++; if (instr_ID !== im_word(32'd4)) $display("FAIL c2_instr got %h exp %h", instr_ID, im_word(32'd4)); else n_pass++;
    tick();
    n_total++; if (fetch_cnt !== 32'd2) $display("FAIL c2_cnt got %0d exp 2", fetch_cnt); else n_pass++;
  endtask

  task automatic test_load_use();
    logic [31:0] pc0, pcid0, instr0, cnt0;
    set_in(2'b10, 2'b00, 32'd0);
    pc0 = m_pc; pcid0 = m_pcid; instr0 = exp_instr();
    n_total++; if (instr_ID !== instr0) $display("FAIL stall_instr got %h exp %h", instr_ID, instr0); else n_pass++;
    tick();
    cnt0 = m_cnt;
    set_in(2'b00, 2'b01, 32'd0);
    n_total++; if (im_addr !== pc0) $display("FAIL stall_pc got %h exp %h", im_addr, pc0); else n_pass++;
    n_total++; if (pc_ID !== pcid0) $display("FAIL stall_pcid got %h exp %h", pc_ID, pcid0); else n_pass++;
    n_total++; if (instr_ID !== instr0) $display("FAIL replay_instr got %h exp %h", instr_ID, instr0); else n_pass++;
    n_total++; if (valid_ID !== 1'b1) $display("FAIL replay_valid got %b exp 1", valid_ID); else n_pass++;
    tick();
    n_total++; if (fetch_cnt !== cnt0) $display("FAIL replay_cnt got %0d exp %0d", fetch_cnt, cnt0); else n_pass++;
  endtask

  task automatic test_branch();
    set_in(2'b01, 2'b10, 32'h0000_0103);
    n_total++; if (instr_ID !== NOP) $display("FAIL br_instr got %h exp %h", instr_ID, NOP); else n_pass++;
    n_total++; if (valid_ID !== 1'b0) $display("FAIL br_valid got %b exp 0", valid_ID); else n_pass++;
    tick();
    set_in(2'b00, 2'b10, 32'd0);
    n_total++; if (im_addr !== 32'h100) $display("FAIL br_pc got %h exp 100", im_addr); else n_pass++;
    tick();
    set_in(2'b00, 2'b00, 32'd0);
    n_total++; if (pc_ID !== 32'h100) $display("FAIL br_pcid got %h exp 100", pc_ID); else n_pass++;
    n_total++; if (instr_ID !== im_word(32'h100)) $display("FAIL br_tgt_instr got %h exp %h", instr_ID, im_word(32'h100)); else n_pass++;
    n_total++; if (valid_ID !== 1'b1) $display("FAIL br_tgt_valid got %b exp 1", valid_ID); else n_pass++;
    tick();
  endtask

  task automatic test_pc_wrap();
    set_in(2'b01, 2'b10, 32'hFFFF_FFFF);
    tick();
    set_in(2'b00, 2'b10, 32'd0);
    n_total++; if (im_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_pre got %h exp fffffffc", im_addr); else n_pass++;
    tick();
    set_in(2'b11, 2'b11, 32'h0000_0AB0);
    n_total++; if (im_addr !== 32'd0) $display("FAIL wrap_pc got %h exp 0", im_addr); else n_pass++;
    n_total++; if (instr_ID !== NOP) $display("FAIL rsv_instr got %h exp %h", instr_ID, NOP); else n_pass++;
    n_total++; if (valid_ID !== 1'b0) $display("FAIL rsv_valid got %b exp 0", valid_ID); else n_pass++;
    tick();
    set_in(2'b00, 2'b00, 32'd0);
    n_total++; if (im_addr !== 32'd4) $display("FAIL rsv_pc got %h exp 4", im_addr); else n_pass++;
    tick();
  endtask

  task automatic test_cnt_wrap();
    force dut.r_fetch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_fetch_cnt;
    m_cnt = 32'hFFFF_FFFF;
    set_in(2'b00, 2'b00, 32'd0);
    n_total++; if (fetch_cnt !== 32'hFFFF_FFFF) $display("FAIL cnt_preset got %h exp ffffffff", fetch_cnt); else n_pass++;
    tick();
    n_total++; if (fetch_cnt !== 32'd0) $display("FAIL cnt_wrap got %h exp 0", fetch_cnt); else n_pass++;
  endtask

  task automatic test_async_reset();
    set_in(2'b10, 2'b00, 32'd0);
    tick();
    set_in(2'b00, 2'b01, 32'd0);
    #2 rst = 1'b1;
    #1;
    n_total++; if (im_addr !== 32'd0) $display("FAIL arst_pc got %h exp 0", im_addr); else n_pass++;
    n_total++; if (pc_ID !== 32'd0) $display("FAIL arst_pcid got %h exp 0", pc_ID); else n_pass++;
    n_total++; if (instr_ID !== NOP) $display("FAIL arst_instr got %h exp %h", instr_ID, NOP); else n_pass++;
    n_total++; if (valid_ID !== 1'b0) $display("FAIL arst_valid got %b exp 0", valid_ID); else n_pass++;
    n_total++; if (fetch_cnt !== 32'd0) $display("FAIL arst_cnt got %h exp 0", fetch_cnt); else n_pass++;
    n_total++; if (IM_CEB !== 1'b1) $display("FAIL arst_ceb got %b exp 1", IM_CEB); else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    set_in(2'b00, 2'b01, 32'd0);
    n_total++; if (instr_ID !== NOP) $display("FAIL reboot_instr got %h exp %h", instr_ID, NOP); else n_pass++;
    n_total++; if (valid_ID !== 1'b0) $display("FAIL reboot_valid got %b exp 0", valid_ID); else n_pass++;
    tick();
    set_in(2'b00, 2'b00, 32'd0);
    n_total++; if (instr_ID !== im_word(32'd0)) $display("FAIL reboot_c1 got %h exp %h", instr_ID, im_word(32'd0)); else n_pass++;
    n_total++; if (pc_ID !== 32'd0) $display("FAIL reboot_pcid got %h exp 0", pc_ID); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] ei;
    logic        ev;
    for (int i = 0; i < 400; i++) begin
      set_in(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
      ei = exp_instr();
      ev = exp_valid();
      n_total++; if (im_addr !== m_pc) $display("FAIL rnd_pc[%0d] got %h exp %h", i, im_addr, m_pc); else n_pass++;
      n_total++; if (pc_ID !== m_pcid) $display("FAIL rnd_pcid[%0d] got %h exp %h", i, pc_ID, m_pcid); else n_pass++;
      n_total++; if (instr_ID !== ei) $display("FAIL rnd_instr[%0d] got %h exp %h", i, instr_ID, ei); else n_pass++;
      n_total++; if (valid_ID !== ev) $display("FAIL rnd_valid[%0d] got %b exp %b", i, valid_ID, ev); else n_pass++;
      n_total++; if (fetch_cnt !== m_cnt) $display("FAIL rnd_cnt[%0d] got %0d exp %0d", i, fetch_cnt, m_cnt); else n_pass++;
      n_total++; if (IM_CEB !== 1'b0) $display("FAIL rnd_ceb[%0d] got %b exp 0", i, IM_CEB); else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_load_use();
    test_branch();
    test_pc_wrap();
    test_cnt_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
